// File: rtl/rv16_rd_wbarb_if.sv
// Functional-unit result channels and writeback port of rv16_rd_wbarb.
// master = units/register-file side, slave = the arbiter.
interface rv16_rd_wbarb_if #(
    parameter int unsigned DATA   = 16,
    parameter int unsigned NUM_FU = 7,
    parameter int unsigned OPW    = 4,
    parameter int unsigned REGW   = 4,
    parameter int unsigned IDXW   = $clog2(NUM_FU)
);
    logic [NUM_FU-1:0]      fu_valid;
    logic [NUM_FU-1:0]      fu_ready;
    logic [NUM_FU*DATA-1:0] fu_data;
    logic [NUM_FU*REGW-1:0] fu_rd;
    logic [NUM_FU*OPW-1:0]  fu_opcode;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [DATA-1:0]        wb_data;
    logic [REGW-1:0]        wb_rd;
    logic [OPW-1:0]         wb_opcode;
    logic [IDXW-1:0]        wb_fu_idx;
    logic [15:0]            wb_stall_cnt;

    modport master (
        output fu_valid, fu_data, fu_rd, fu_opcode, wb_ready,
        input  fu_ready, wb_valid, wb_data, wb_rd, wb_opcode, wb_fu_idx, wb_stall_cnt
    );

    modport slave (
        input  fu_valid, fu_data, fu_rd, fu_opcode, wb_ready,
        output fu_ready, wb_valid, wb_data, wb_rd, wb_opcode, wb_fu_idx, wb_stall_cnt
    );
endinterface

// File: rtl/rv16_rd_wbarb.sv
// Writeback arbiter and result register for the rv16 datapath.
// Define RV16_WB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module rv16_rd_wbarb #(
    parameter int unsigned DATA   = 16,
    parameter int unsigned NUM_FU = 7,
    parameter int unsigned OPW    = 4,
    parameter int unsigned REGW   = 4,
    parameter int unsigned IDXW   = $clog2(NUM_FU)
) (
    input  logic          clk,
    input  logic          rst,
    rv16_rd_wbarb_if.slave bus
);
    logic [IDXW-1:0]   ptr;
    logic              free;
    logic              grant_any;
    logic [IDXW-1:0]   grant_idx;
    logic [NUM_FU-1:0] ready_vec;
    logic [DATA-1:0]   sel_data;
    logic [REGW-1:0]   sel_rd;
    logic [OPW-1:0]    sel_op;

    logic              wb_valid_q;
    logic [DATA-1:0]   wb_data_q;
    logic [REGW-1:0]   wb_rd_q;
    logic [OPW-1:0]    wb_opcode_q;
    logic [IDXW-1:0]   wb_fu_idx_q;
    logic [15:0]       stall_q;

    // Reset gates the grant so no unit is acknowledged in a reset cycle.
    assign free = ~rst & (~wb_valid_q | bus.wb_ready);

    // Search upward from ptr with wrap; ptr is tied to 0 in the fixed build.
    always_comb begin : search
        int unsigned cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_FU) cand = cand - NUM_FU;
            if (free && !grant_any && bus.fu_valid[cand[IDXW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (grant_any) ready_vec[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_data = '0;
        sel_rd   = '0;
        sel_op   = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            if (grant_idx == IDXW'(k)) begin
                sel_data = bus.fu_data[k*DATA +: DATA];
                sel_rd   = bus.fu_rd[k*REGW +: REGW];
                sel_op   = bus.fu_opcode[k*OPW +: OPW];
            end
        end
    end

`ifdef RV16_WB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == IDXW'(NUM_FU - 1)) ? '0 : grant_idx + IDXW'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_opcode_q <= '0;
            wb_fu_idx_q <= '0;
            stall_q     <= '0;
        end else begin
            if (wb_valid_q && !bus.wb_ready && stall_q != '1)
                stall_q <= stall_q + 16'd1;
            // A grant to an x0 destination is consumed but leaves the slot empty.
            if (free) begin
                wb_valid_q <= 1'b0;
                if (grant_any && sel_rd != '0) begin
                    wb_valid_q  <= 1'b1;
                    wb_data_q   <= sel_data;
                    wb_rd_q     <= sel_rd;
                    wb_opcode_q <= sel_op;
                    wb_fu_idx_q <= grant_idx;
                end
            end
        end
    end

    assign bus.fu_ready     = ready_vec;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_opcode    = wb_opcode_q;
    assign bus.wb_fu_idx    = wb_fu_idx_q;
    assign bus.wb_stall_cnt = stall_q;
endmodule

// File: tb/tb_rv16_rd_wbarb.sv
// Directed bench for rv16_rd_wbarb; expectations follow RV16_WB_RR_EN.
module tb_rv16_rd_wbarb;
    localparam int unsigned DATA   = 16;
    localparam int unsigned NUM_FU = 7;
    localparam int unsigned OPW    = 4;
    localparam int unsigned REGW   = 4;
    localparam int unsigned IDXW   = $clog2(NUM_FU);
`ifdef RV16_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    rv16_rd_wbarb_if #(.DATA(DATA), .NUM_FU(NUM_FU), .OPW(OPW), .REGW(REGW), .IDXW(IDXW)) bus ();

    rv16_rd_wbarb #(.DATA(DATA), .NUM_FU(NUM_FU), .OPW(OPW), .REGW(REGW), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int unsigned i, input logic v, input logic [15:0] d,
                          input logic [3:0] rd, input logic [3:0] op);
        bus.fu_valid[i]                = v;
        bus.fu_data[i*DATA +: DATA]    = d;
        bus.fu_rd[i*REGW +: REGW]      = rd;
        bus.fu_opcode[i*OPW +: OPW]    = op;
    endtask

    task automatic clear_all();
        bus.fu_valid  = '0;
        bus.fu_data   = '0;
        bus.fu_rd     = '0;
        bus.fu_opcode = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        bus.wb_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wb_ready = 1'b1;
        bus.fu_valid = '1;
        bus.fu_data  = '1;
        bus.fu_rd    = '1;
        bus.fu_opcode = '1;
        #1;
        tests_run++; if (bus.fu_ready !== 7'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want %b", bus.fu_ready, 7'b0); end
        tick();
        tick();
        tests_run++; if (bus.fu_ready !== 7'b0) begin tests_failed++; $display("FAIL reset_ready2: got %b want %b", bus.fu_ready, 7'b0); end
        tests_run++; if (bus.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.wb_valid); end
        tests_run++; if (bus.wb_data !== 16'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0000", bus.wb_data); end
        tests_run++; if (bus.wb_rd !== 4'h0 || bus.wb_opcode !== 4'h0) begin tests_failed++; $display("FAIL reset_rd_op: got %h/%h want 0/0", bus.wb_rd, bus.wb_opcode); end
        tests_run++; if (bus.wb_fu_idx !== 3'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d want 0", bus.wb_fu_idx); end
        tests_run++; if (bus.wb_stall_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_stall: got %h want 0000", bus.wb_stall_cnt); end
        clear_all();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        set_fu(0, 1'b1, 16'h1234, 4'd3, 4'h0);
        #1;
        tests_run++; if (bus.fu_ready !== 7'b0000001) begin tests_failed++; $display("FAIL basic_ready: got %b want 0000001", bus.fu_ready); end
        tick();
        bus.fu_valid[0] = 1'b0;
        tests_run++; if (bus.wb_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b want 1", bus.wb_valid); end
        tests_run++; if (bus.wb_data !== 16'h1234) begin tests_failed++; $display("FAIL basic_data: got %h want 1234", bus.wb_data); end
        tests_run++; if (bus.wb_rd !== 4'd3 || bus.wb_opcode !== 4'h0) begin tests_failed++; $display("FAIL basic_rd_op: got %h/%h want 3/0", bus.wb_rd, bus.wb_opcode); end
        tests_run++; if (bus.wb_fu_idx !== 3'd0) begin tests_failed++; $display("FAIL basic_idx: got %0d want 0", bus.wb_fu_idx); end
        tick();
        tests_run++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 16'h1234) begin tests_failed++; $display("FAIL basic_drain: got v=%b d=%h want v=0 d=1234", bus.wb_valid, bus.wb_data); end
    endtask

    task automatic test_round_robin();
        logic [IDXW-1:0]   g;
        logic [NUM_FU-1:0] exp_ready;
        do_reset();
        for (int unsigned i = 0; i < NUM_FU; i++)
            set_fu(i, 1'b1, 16'h0100 + 16'(i), 4'(i + 1), 4'(i));
        for (int unsigned c = 0; c < 8; c++) begin
            g = RR ? IDXW'(c % NUM_FU) : '0;
            exp_ready = NUM_FU'(1) << g;
            #1;
            tests_run++; if (bus.fu_ready !== exp_ready) begin tests_failed++; $display("FAIL rr_ready[%0d]: got %b want %b", c, bus.fu_ready, exp_ready); end
            tick();
            tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_fu_idx !== g) begin tests_failed++; $display("FAIL rr_idx[%0d]: got v=%b i=%0d want v=1 i=%0d", c, bus.wb_valid, bus.wb_fu_idx, g); end
            tests_run++; if (bus.wb_data !== (16'h0100 + 16'(g))) begin tests_failed++; $display("FAIL rr_data[%0d]: got %h want %h", c, bus.wb_data, 16'h0100 + 16'(g)); end
        end
        clear_all();
        tick();
    endtask

    task automatic test_stall();
        int unsigned ready_seen;
        ready_seen = 0;
        do_reset();
        set_fu(2, 1'b1, 16'hBEEF, 4'd5, 4'hA);
        tick();
        bus.fu_valid[2] = 1'b0;
        tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'hBEEF) begin tests_failed++; $display("FAIL stall_load: got v=%b d=%h want v=1 d=beef", bus.wb_valid, bus.wb_data); end
        bus.wb_ready = 1'b0;
        set_fu(1, 1'b1, 16'hC0DE, 4'd6, 4'h3);
        for (int unsigned c = 0; c < 5; c++) begin
            #1;
            if (bus.fu_ready !== 7'b0) ready_seen++;
            tick();
        end
        tests_run++; if (ready_seen !== 0) begin tests_failed++; $display("FAIL stall_ready: got %0d grant cycles want 0", ready_seen); end
        tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'hBEEF || bus.wb_rd !== 4'd5 || bus.wb_opcode !== 4'hA || bus.wb_fu_idx !== 3'd2) begin
            tests_failed++; $display("FAIL stall_hold: got v=%b d=%h rd=%h op=%h i=%0d want 1 beef 5 a 2", bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_opcode, bus.wb_fu_idx); end
        tests_run++; if (bus.wb_stall_cnt !== 16'd5) begin tests_failed++; $display("FAIL stall_cnt5: got %0d want 5", bus.wb_stall_cnt); end
        repeat (16'hFFFE - 5) @(posedge clk);
        #1;
        tests_run++; if (bus.wb_stall_cnt !== 16'hFFFE) begin tests_failed++; $display("FAIL stall_cnt_fffe: got %h want fffe", bus.wb_stall_cnt); end
        tick(); tick(); tick();
        tests_run++; if (bus.wb_stall_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL stall_sat: got %h want ffff", bus.wb_stall_cnt); end
        bus.wb_ready = 1'b1;
        #1;
        tests_run++; if (bus.fu_ready !== 7'b0000010) begin tests_failed++; $display("FAIL refill_ready: got %b want 0000010", bus.fu_ready); end
        tick();
        bus.fu_valid[1] = 1'b0;
        tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'hC0DE || bus.wb_fu_idx !== 3'd1) begin
            tests_failed++; $display("FAIL refill_data: got v=%b d=%h i=%0d want 1 c0de 1", bus.wb_valid, bus.wb_data, bus.wb_fu_idx); end
        tests_run++; if (bus.wb_stall_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL stall_after: got %h want ffff", bus.wb_stall_cnt); end
        tick();
    endtask

    task automatic test_x0_discard();
        do_reset();
        set_fu(0, 1'b1, 16'h5555, 4'd1, 4'h2);
        tick();
        bus.fu_valid[0] = 1'b0;
        set_fu(4, 1'b1, 16'hAAAA, 4'd0, 4'h7);
        #1;
        tests_run++; if (bus.fu_ready !== 7'b0010000) begin tests_failed++; $display("FAIL x0_ready: got %b want 0010000", bus.fu_ready); end
        tick();
        bus.fu_valid[4] = 1'b0;
        tests_run++; if (bus.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL x0_valid: got %b want 0", bus.wb_valid); end
        tests_run++; if (bus.wb_data !== 16'h5555 || bus.wb_rd !== 4'd1 || bus.wb_fu_idx !== 3'd0) begin
            tests_failed++; $display("FAIL x0_fields: got d=%h rd=%h i=%0d want 5555 1 0", bus.wb_data, bus.wb_rd, bus.wb_fu_idx); end
        set_fu(3, 1'b1, 16'h3333, 4'd3, 4'h1);
        set_fu(5, 1'b1, 16'h5050, 4'd5, 4'h1);
        #1;
        tests_run++; if (bus.fu_ready !== (RR ? 7'b0100000 : 7'b0001000)) begin
            tests_failed++; $display("FAIL x0_ptr: got %b want %b", bus.fu_ready, RR ? 7'b0100000 : 7'b0001000); end
        tick();
        tests_run++; if (bus.wb_fu_idx !== (RR ? 3'd5 : 3'd3)) begin tests_failed++; $display("FAIL x0_next_idx: got %0d want %0d", bus.wb_fu_idx, RR ? 3'd5 : 3'd3); end
        clear_all();
        tick();
    endtask

    task automatic test_wrap();
        logic [IDXW-1:0] first, second;
        logic [15:0]     d_first, d_second;
        first    = RR ? 3'd6 : 3'd5;
        second   = RR ? 3'd5 : 3'd6;
        d_first  = RR ? 16'h6B6B : 16'h5A5A;
        d_second = RR ? 16'h5A5A : 16'h6B6B;
        do_reset();
        set_fu(5, 1'b1, 16'h0505, 4'd1, 4'h5);
        tick();
        bus.fu_valid[5] = 1'b0;
        set_fu(5, 1'b1, 16'h5A5A, 4'd2, 4'h5);
        set_fu(6, 1'b1, 16'h6B6B, 4'd3, 4'h6);
        #1;
        tests_run++; if (bus.fu_ready !== (NUM_FU'(1) << first)) begin tests_failed++; $display("FAIL wrap_ready1: got %b want %b", bus.fu_ready, NUM_FU'(1) << first); end
        tick();
        bus.fu_valid[first] = 1'b0;
        tests_run++; if (bus.wb_fu_idx !== first || bus.wb_data !== d_first) begin
            tests_failed++; $display("FAIL wrap_first: got i=%0d d=%h want i=%0d d=%h", bus.wb_fu_idx, bus.wb_data, first, d_first); end
        #1;
        tests_run++; if (bus.fu_ready !== (NUM_FU'(1) << second)) begin tests_failed++; $display("FAIL wrap_ready2: got %b want %b", bus.fu_ready, NUM_FU'(1) << second); end
        tick();
        bus.fu_valid[second] = 1'b0;
        tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_fu_idx !== second || bus.wb_data !== d_second) begin
            tests_failed++; $display("FAIL wrap_second: got v=%b i=%0d d=%h want v=1 i=%0d d=%h", bus.wb_valid, bus.wb_fu_idx, bus.wb_data, second, d_second); end
        clear_all();
        tick();
    endtask

    task automatic test_reset_hold();
        do_reset();
        set_fu(0, 1'b1, 16'h0F0F, 4'd2, 4'h1);
        tick();
        bus.fu_valid[0] = 1'b0;
        bus.wb_ready = 1'b0;
        set_fu(2, 1'b1, 16'h2222, 4'd4, 4'h2);
        tick();
        bus.wb_ready = 1'b1;
        rst = 1'b1;
        #1;
        tests_run++; if (bus.fu_ready !== 7'b0) begin tests_failed++; $display("FAIL rsthold_ready: got %b want 0000000", bus.fu_ready); end
        tick();
        tests_run++; if (bus.wb_valid !== 1'b0 || bus.fu_ready !== 7'b0) begin
            tests_failed++; $display("FAIL rsthold_after: got v=%b r=%b want v=0 r=0000000", bus.wb_valid, bus.fu_ready); end
        tests_run++; if (bus.wb_data !== 16'h0 || bus.wb_stall_cnt !== 16'h0) begin
            tests_failed++; $display("FAIL rsthold_clear: got d=%h s=%h want 0000 0000", bus.wb_data, bus.wb_stall_cnt); end
        rst = 1'b0;
        set_fu(0, 1'b1, 16'h0A0A, 4'd7, 4'h3);
        #1;
        tests_run++; if (bus.fu_ready !== 7'b0000001) begin tests_failed++; $display("FAIL rsthold_ptr0: got %b want 0000001", bus.fu_ready); end
        tick();
        bus.fu_valid[0] = 1'b0;
        tests_run++; if (bus.wb_data !== 16'h0A0A || bus.wb_fu_idx !== 3'd0) begin
            tests_failed++; $display("FAIL rsthold_u0: got d=%h i=%0d want 0a0a 0", bus.wb_data, bus.wb_fu_idx); end
        #1;
        tests_run++; if (bus.fu_ready !== 7'b0000100) begin tests_failed++; $display("FAIL rsthold_u2_ready: got %b want 0000100", bus.fu_ready); end
        tick();
        bus.fu_valid[2] = 1'b0;
        tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'h2222 || bus.wb_fu_idx !== 3'd2) begin
            tests_failed++; $display("FAIL rsthold_u2: got v=%b d=%h i=%0d want 1 2222 2", bus.wb_valid, bus.wb_data, bus.wb_fu_idx); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.wb_ready = 1'b1;
        clear_all();
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_x0_discard();
        test_wrap();
        test_reset_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/rv16_rd_wbarb.md
# rv16_rd_wbarb

Parametrised writeback arbiter and result register for the rv16 datapath. It collects results from `NUM_FU` functional units (ADD, SUB, MUL, DIV, XOR, AND, OR by default), each with its own valid/ready handshake. It grants one unit per cycle, round-robin or fixed priority, and registers the winning result, destination register and opcode into a single writeback stage that feeds the register file write port. It replaces opcode-decoded combinational result selection, so multi-cycle units (MUL/DIV) can complete out of order and stall cleanly.

## Interface
Parameters:
- `DATA`, 16, result width
- `NUM_FU`, 7, number of functional-unit channels (2..16, need not be a power of two)
- `OPW`, 4, opcode width
- `REGW`, 4, destination register index width
- `IDXW`, `$clog2(NUM_FU)`, grant index width (derived)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `fu_valid`  in  NUM_FU  result valid, one bit per unit
- `fu_ready`  out  NUM_FU  result accepted, one-hot or zero
- `fu_data`  in  NUM_FU*DATA  results, unit i at `[i*DATA +: DATA]`
- `fu_rd`  in  NUM_FU*REGW  destination register per unit
- `fu_opcode`  in  NUM_FU*OPW  opcode tag per unit
- `wb_valid`  out  1  writeback register holds a result
- `wb_ready`  in  1  register file consumes the result
- `wb_data`  out  DATA  registered result
- `wb_rd`  out  REGW  registered destination
- `wb_opcode`  out  OPW  registered opcode
- `wb_fu_idx`  out  IDXW  index of the unit that produced the result
- `wb_stall_cnt`  out  16  saturating count of cycles with `wb_valid & ~wb_ready`

## Operation
- Slot free condition: `free = ~wb_valid | wb_ready`.
- Grant: when `free`, exactly one unit with `fu_valid[i]=1` gets `fu_ready[i]=1`. Otherwise `fu_ready = 0`.
- A unit transfers on `fu_valid[i] & fu_ready[i]`. The unit must hold data, rd and opcode stable while valid and not ready.
- On transfer with `fu_rd != 0`:
  - `wb_data`, `wb_rd` and `wb_opcode` load from unit i.
  - `wb_fu_idx` loads i.
  - `wb_valid` is 1 next cycle.
- On transfer with `fu_rd == 0` (x0): the result is consumed and discarded. `wb_valid` is 0 next cycle and the data fields are unchanged.
- `free` with no valid unit: `wb_valid` is 0 next cycle.
- `wb_valid & ~wb_ready`: all wb outputs hold and no grant is issued.
- Round-robin pointer `ptr`:
  - The search starts at `ptr` and goes upward, wrapping from `NUM_FU-1` to 0.
  - After a grant to i, `ptr` becomes `(i+1) mod NUM_FU`. The x0 discard counts as a grant.
  - `ptr` is unchanged when no grant is issued.
- `wb_stall_cnt` increments each cycle `wb_valid & ~wb_ready` holds and saturates at 16'hFFFF.
- `fu_ready` is combinational from `fu_valid`, `wb_valid`, `wb_ready` and `ptr`. Units must not derive `fu_valid` from `fu_ready`.

## Timing
- Latency is 1 cycle from the transfer edge to `wb_valid`/`wb_data`.
- Throughput is one result per cycle when `wb_ready` stays high.
- Reset values: `wb_valid=0`, `wb_data=0`, `wb_rd=0`, `wb_opcode=0`, `wb_fu_idx=0`, `wb_stall_cnt=0`, `ptr=0`.
- While `rst=1`, `fu_ready=0`.
- Reset during a held result discards that result. No unit is acknowledged in the reset cycle.
- Consume-and-refill in the same cycle: with `wb_valid=1`, `wb_ready=1` and a unit valid, the old result is consumed and the new one is loaded at the same edge. There is no bubble.

## Configuration
- `RV16_WB_RR_EN` defined: round-robin arbitration as above.
- `RV16_WB_RR_EN` undefined: fixed priority, lowest index wins. `ptr` is not implemented and always reads 0, which can starve high indices.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then unit 0 valid with data 16'h1234, rd 3, opcode 4'h0 and `wb_ready=1` -> the next cycle has `wb_valid=1`, `wb_data=16'h1234`, `wb_rd=3`, `wb_fu_idx=0`.
- All 7 units continuously valid, `wb_ready=1`, RR build -> grants run 0,1,…,6,0 over 8 cycles. Fixed build -> unit 0 is granted every cycle.
- `wb_ready=0` for 5 cycles with `wb_valid=1` -> outputs hold, `fu_ready=0` throughout, `wb_stall_cnt=5`. Preload the counter to 16'hFFFE and stall 3 cycles -> it reads 16'hFFFF.
- Unit 4 valid with rd 0 -> `fu_ready[4]=1` for one cycle, `wb_valid` stays 0, and `ptr` becomes 5.
- Units 5 and 6 valid with `ptr=6` -> unit 6 is granted and `ptr` wraps to 0. Then unit 5 is granted, and the results appear on consecutive cycles.
- `rst` asserted while `wb_valid=1` and unit 2 valid -> the next cycle has `wb_valid=0`, `fu_ready=0` and `ptr=0`, and unit 2 is not acknowledged.
